// File: rtl/fetch_pkg.sv
// ============================================================================
// fetch_pkg -- shared state encodings, NOP and default widths for the IF stage.
// Rev 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int unsigned DEF_BPC    = 7;
  localparam int unsigned DEF_BINSTR = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_skid_buf.sv
// ============================================================================
// fetch_skid_buf -- one-entry instruction buffer with load, clear and full flag.
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_skid_buf
  import fetch_pkg::*;
#(
  parameter int unsigned bINSTR = DEF_BINSTR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [bINSTR-1:0] din,
  output logic [bINSTR-1:0] dout,
  output logic              full
);

  logic [bINSTR-1:0] data_q, data_d;
  logic              full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load) begin
      data_d = din;
      full_d = 1'b1;
    end else if (clear) begin
      data_d = bINSTR'(NOP_INSTR);
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign dout = data_q;
  assign full = full_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// if_fetch_stage -- imem request FSM, next-PC select, skid buffer and IF/ID reg.
// FETCH_PERF_EN adds saturating perf_fetched / perf_bubbles counters. Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter int unsigned bPC    = DEF_BPC,
  parameter int unsigned bINSTR = DEF_BINSTR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [bPC-1:0]    pc_in,
  output logic [bPC-1:0]    pc_next,
  output logic              imem_req,
  output logic [bPC-1:0]    imem_addr,
  input  logic              imem_valid,
  input  logic [bINSTR-1:0] imem_instr,
  input  logic              stall,
  input  logic              flush,
  input  logic [bPC-1:0]    redirect_pc,
  output logic [bINSTR-1:0] if_id_instr,
  output logic [bPC-1:0]    if_id_pc,
  output logic [bPC-1:0]    if_id_pc_plus1,
  output logic              if_id_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_bubbles
`endif
);

  fetch_state_e      state_q, state_d;
  logic [bINSTR-1:0] if_id_instr_q, if_id_instr_d;
  logic [bPC-1:0]    if_id_pc_q, if_id_pc_d;
  logic [bPC-1:0]    if_id_pc_plus1_q, if_id_pc_plus1_d;
  logic              if_id_valid_q, if_id_valid_d;

  logic              accept;
  logic [bINSTR-1:0] accept_instr;
  logic              skid_load, skid_clear, skid_full;
  logic [bINSTR-1:0] skid_data;
  logic [bPC-1:0]    pc_plus1;
  logic              bubble;

  assign pc_plus1  = pc_in + bPC'(1);
  assign imem_addr = pc_in;

  fetch_skid_buf #(
    .bINSTR (bINSTR)
  ) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .clear (skid_clear),
    .din   (imem_instr),
    .dout  (skid_data),
    .full  (skid_full)
  );

  // Request/response FSM; flush outranks stall, which outranks imem_valid.
  always_comb begin
    state_d      = state_q;
    imem_req     = 1'b0;
    accept       = 1'b0;
    accept_instr = imem_instr;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    case (state_q)
      ST_REQ: begin
        imem_req = 1'b1;
        state_d  = flush ? ST_DRAIN : ST_WAIT;
      end
      ST_WAIT: begin
        if (flush) begin
          state_d = imem_valid ? ST_REQ : ST_DRAIN;
        end else if (imem_valid) begin
          if (stall) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            accept  = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (flush) begin
          skid_clear = 1'b1;
          state_d    = ST_REQ;
        end else if (!stall && skid_full) begin
          accept       = 1'b1;
          accept_instr = skid_data;
          skid_clear   = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_DRAIN: begin
        // The in-flight response is the one being discarded.
        if (!flush && imem_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    pc_next = pc_in;
    if (flush) begin
      pc_next = redirect_pc;
    end else if (accept) begin
      pc_next = pc_plus1;
    end
  end

  always_comb begin
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_d       = if_id_pc_q;
    if_id_pc_plus1_d = if_id_pc_plus1_q;
    if_id_valid_d    = if_id_valid_q;
    bubble           = 1'b0;
    if (flush) begin
      if_id_instr_d = bINSTR'(NOP_INSTR);
      if_id_valid_d = 1'b0;
      bubble        = 1'b1;
    end else if (accept) begin
      if_id_instr_d    = accept_instr;
      if_id_pc_d       = pc_in;
      if_id_pc_plus1_d = pc_plus1;
      if_id_valid_d    = 1'b1;
    end else if (!stall) begin
      if_id_valid_d = 1'b0;
      bubble        = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_REQ;
      if_id_instr_q    <= '0;
      if_id_pc_q       <= '0;
      if_id_pc_plus1_q <= '0;
      if_id_valid_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_q       <= if_id_pc_d;
      if_id_pc_plus1_q <= if_id_pc_plus1_d;
      if_id_valid_q    <= if_id_valid_d;
    end
  end

  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus1 = if_id_pc_plus1_q;
  assign if_id_valid    = if_id_valid_q;

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_bubbles_q, perf_bubbles_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (accept && (perf_fetched_q != 16'hFFFF)) begin
      perf_fetched_d = perf_fetched_q + 16'd1;
    end
    if (bubble && (perf_bubbles_q != 16'hFFFF)) begin
      perf_bubbles_d = perf_bubbles_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetched_q <= 16'd0;
      perf_bubbles_q <= 16'd0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  logic unused_bubble;
  assign unused_bubble = bubble;
`endif

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// tb_if_fetch_stage -- directed vector table, random run against a
// transaction-level model, and an asynchronous reset sequence. Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

  localparam int PCMOD = 128;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  pc_in = '0;
  logic [6:0]  pc_next;
  logic        imem_req;
  logic [6:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_instr = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [6:0]  redirect_pc = '0;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_pc;
  logic [6:0]  if_id_pc_plus1;
  logic        if_id_valid;
`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;
`endif

  always #5 clock = ~clock;

  if_fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .pc_in          (pc_in),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_valid     (imem_valid),
    .imem_instr     (imem_instr),
    .stall          (stall),
    .flush          (flush),
    .redirect_pc    (redirect_pc),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Ends on a negedge with reset just released.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; imem_valid = 1'b0;
    imem_instr = '0; pc_in = '0; redirect_pc = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [6:0]  pc;
    logic        st, fl, v;
    logic [31:0] instr;
    logic [6:0]  rd;
    logic        e_req;
    logic [6:0]  e_next;
    logic        e_v;
    logic [6:0]  e_pc, e_pc1;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  // Reference model: request pending / response in flight / to be dropped / buffered.
  logic        m_issue, m_inflight, m_drop;
  logic [31:0] m_skid [$];
  logic [31:0] m_instr;
  logic [6:0]  m_pc, m_pc1;
  logic        m_valid;
  int          m_fetched, m_bubbles;

  task automatic model_reset();
    m_issue = 1'b1; m_inflight = 1'b0; m_drop = 1'b0; m_skid.delete();
    m_instr = '0; m_pc = '0; m_pc1 = '0; m_valid = 1'b0;
    m_fetched = 0; m_bubbles = 0;
  endtask

  task automatic model_step(input logic st, input logic fl, input logic v,
                            input logic [31:0] ins, input logic [6:0] pc,
                            input logic [6:0] rd,
                            output logic e_req, output logic [6:0] e_next);
    logic        took;
    logic [31:0] took_instr;
    e_req = m_issue; e_next = pc; took = 1'b0; took_instr = '0;
    if (fl) begin
      e_next = rd;
      if (m_issue) begin
        m_issue = 1'b0; m_inflight = 1'b1; m_drop = 1'b1;
      end else if (m_skid.size() != 0) begin
        m_skid.delete(); m_issue = 1'b1;
      end else if (m_inflight && !m_drop) begin
        if (v) begin m_inflight = 1'b0; m_issue = 1'b1; end
        else m_drop = 1'b1;
      end
      m_instr = '0; m_valid = 1'b0;
    end else begin
      if (m_issue) begin
        m_issue = 1'b0; m_inflight = 1'b1;
      end else if (m_skid.size() != 0) begin
        if (!st) begin took = 1'b1; took_instr = m_skid.pop_front(); end
      end else if (m_inflight && v) begin
        m_inflight = 1'b0;
        if (m_drop) begin m_drop = 1'b0; m_issue = 1'b1; end
        else if (st) m_skid.push_back(ins);
        else begin took = 1'b1; took_instr = ins; end
      end
      if (took) begin
        m_instr = took_instr; m_pc = pc; m_pc1 = 7'((int'(pc) + 1) % PCMOD);
        m_valid = 1'b1; e_next = m_pc1; m_issue = 1'b1;
        if (m_fetched < 65535) m_fetched++;
      end else if (!st) begin
        m_valid = 1'b0;
      end
    end
    if ((fl || (!took && !st)) && m_bubbles < 65535) m_bubbles++;
  endtask

  logic        r_v, r_st, r_fl, e_req;
  logic [31:0] r_ins, mem_data;
  logic [6:0]  r_rd, e_next, pc_reg;
  int          mem_wait;

  initial begin
    //            pc     st    fl    v     instr         rd     req   next   ev    epc    epc1   einstr
    tbl[0]  = '{7'h00,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h00, 1'b0,7'h00,7'h00,32'h0};
    tbl[1]  = '{7'h00,1'b0,1'b0,1'b1,32'h11111111, 7'h00, 1'b0,7'h01, 1'b1,7'h00,7'h01,32'h11111111};
    tbl[2]  = '{7'h01,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h01, 1'b0,7'h00,7'h01,32'h11111111};
    tbl[3]  = '{7'h01,1'b0,1'b0,1'b1,32'h22222222, 7'h00, 1'b0,7'h02, 1'b1,7'h01,7'h02,32'h22222222};
    tbl[4]  = '{7'h02,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h02, 1'b0,7'h01,7'h02,32'h22222222};
    tbl[5]  = '{7'h02,1'b0,1'b0,1'b1,32'h33333333, 7'h00, 1'b0,7'h03, 1'b1,7'h02,7'h03,32'h33333333};
    tbl[6]  = '{7'h05,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h05, 1'b0,7'h02,7'h03,32'h33333333};
    tbl[7]  = '{7'h05,1'b1,1'b0,1'b1,32'h2002000A, 7'h00, 1'b0,7'h05, 1'b0,7'h02,7'h03,32'h33333333};
    tbl[8]  = '{7'h05,1'b1,1'b0,1'b0,32'h0,        7'h00, 1'b0,7'h05, 1'b0,7'h02,7'h03,32'h33333333};
    tbl[9]  = '{7'h05,1'b1,1'b0,1'b0,32'h0,        7'h00, 1'b0,7'h05, 1'b0,7'h02,7'h03,32'h33333333};
    tbl[10] = '{7'h05,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b0,7'h06, 1'b1,7'h05,7'h06,32'h2002000A};
    tbl[11] = '{7'h06,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h06, 1'b0,7'h05,7'h06,32'h2002000A};
    tbl[12] = '{7'h06,1'b0,1'b1,1'b0,32'h0,        7'h40, 1'b0,7'h40, 1'b0,7'h05,7'h06,32'h0};
    tbl[13] = '{7'h40,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b0,7'h40, 1'b0,7'h05,7'h06,32'h0};
    tbl[14] = '{7'h40,1'b0,1'b0,1'b1,32'hDEADBEEF, 7'h00, 1'b0,7'h40, 1'b0,7'h05,7'h06,32'h0};
    tbl[15] = '{7'h40,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h40, 1'b0,7'h05,7'h06,32'h0};
    tbl[16] = '{7'h40,1'b0,1'b0,1'b1,32'h44444444, 7'h00, 1'b0,7'h41, 1'b1,7'h40,7'h41,32'h44444444};
    tbl[17] = '{7'h7F,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h7F, 1'b0,7'h40,7'h41,32'h44444444};
    tbl[18] = '{7'h7F,1'b0,1'b0,1'b1,32'h55555555, 7'h00, 1'b0,7'h00, 1'b1,7'h7F,7'h00,32'h55555555};
    tbl[19] = '{7'h00,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h00, 1'b0,7'h7F,7'h00,32'h55555555};
    tbl[20] = '{7'h00,1'b1,1'b0,1'b1,32'h66666666, 7'h00, 1'b0,7'h00, 1'b0,7'h7F,7'h00,32'h55555555};
    tbl[21] = '{7'h00,1'b1,1'b1,1'b0,32'h0,        7'h10, 1'b0,7'h10, 1'b0,7'h7F,7'h00,32'h0};
    tbl[22] = '{7'h10,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h10, 1'b0,7'h7F,7'h00,32'h0};
    tbl[23] = '{7'h10,1'b0,1'b0,1'b1,32'h77777777, 7'h00, 1'b0,7'h11, 1'b1,7'h10,7'h11,32'h77777777};
    tbl[24] = '{7'h11,1'b1,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h11, 1'b1,7'h10,7'h11,32'h77777777};
    tbl[25] = '{7'h11,1'b1,1'b0,1'b0,32'h0,        7'h00, 1'b0,7'h11, 1'b1,7'h10,7'h11,32'h77777777};
    tbl[26] = '{7'h11,1'b1,1'b1,1'b1,32'h99999999, 7'h20, 1'b0,7'h20, 1'b0,7'h10,7'h11,32'h0};
    tbl[27] = '{7'h20,1'b0,1'b1,1'b0,32'h0,        7'h30, 1'b1,7'h30, 1'b0,7'h10,7'h11,32'h0};
    tbl[28] = '{7'h30,1'b0,1'b0,1'b1,32'h88888888, 7'h00, 1'b0,7'h30, 1'b0,7'h10,7'h11,32'h0};
    tbl[29] = '{7'h30,1'b0,1'b0,1'b0,32'h0,        7'h00, 1'b1,7'h30, 1'b0,7'h10,7'h11,32'h0};

    // Reset state, sampled while reset is still asserted.
    #7;
    check("reset_if_id_instr", if_id_instr, 32'h0);
    check("reset_if_id_pc", 32'(if_id_pc), 32'h0);
    check("reset_if_id_pc_plus1", 32'(if_id_pc_plus1), 32'h0);
    check("reset_if_id_valid", 32'(if_id_valid), 32'h0);
    check("reset_imem_req", 32'(imem_req), 32'h1);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      pc_in = tbl[i].pc; stall = tbl[i].st; flush = tbl[i].fl;
      imem_valid = tbl[i].v; imem_instr = tbl[i].instr; redirect_pc = tbl[i].rd;
      #1;
      check($sformatf("row%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      check($sformatf("row%0d_imem_addr", i), 32'(imem_addr), 32'(tbl[i].pc));
      check($sformatf("row%0d_pc_next", i), 32'(pc_next), 32'(tbl[i].e_next));
      @(posedge clock); #1;
      check($sformatf("row%0d_if_id_valid", i), 32'(if_id_valid), 32'(tbl[i].e_v));
      check($sformatf("row%0d_if_id_pc", i), 32'(if_id_pc), 32'(tbl[i].e_pc));
      check($sformatf("row%0d_if_id_pc_plus1", i), 32'(if_id_pc_plus1), 32'(tbl[i].e_pc1));
      check($sformatf("row%0d_if_id_instr", i), if_id_instr, tbl[i].e_instr);
      @(negedge clock);
    end
`ifdef FETCH_PERF_EN
    check("tbl_perf_fetched", 32'(perf_fetched), 32'd7);
    check("tbl_perf_bubbles", 32'(perf_bubbles), 32'd17);
`endif

    // Randomized run: bench owns the PC register and a variable-latency memory.
    do_reset();
    model_reset();
    pc_reg = '0; mem_wait = 0; mem_data = '0;
    for (int c = 0; c < 3000; c++) begin
      r_v = 1'b0;
      if (mem_wait > 0) begin
        mem_wait--;
        r_v = (mem_wait == 0);
      end
      r_st  = ($urandom_range(0, 3) == 0);
      r_fl  = ($urandom_range(0, 11) == 0);
      // A flush colliding with the drained response would orphan the redirect.
      if (r_fl && m_inflight && m_drop && r_v) r_fl = 1'b0;
      r_ins = r_v ? mem_data : $urandom;
      r_rd  = 7'($urandom);
      pc_in = pc_reg; stall = r_st; flush = r_fl; imem_valid = r_v;
      imem_instr = r_ins; redirect_pc = r_rd;
      model_step(r_st, r_fl, r_v, r_ins, pc_reg, r_rd, e_req, e_next);
      if (e_req) begin
        mem_wait = $urandom_range(1, 3);
        mem_data = $urandom ^ 32'(pc_reg);
      end
      #1;
      check("rand_imem_req", 32'(imem_req), 32'(e_req));
      check("rand_imem_addr", 32'(imem_addr), 32'(pc_reg));
      check("rand_pc_next", 32'(pc_next), 32'(e_next));
      @(posedge clock); #1;
      check("rand_if_id_valid", 32'(if_id_valid), 32'(m_valid));
      check("rand_if_id_pc", 32'(if_id_pc), 32'(m_pc));
      check("rand_if_id_pc_plus1", 32'(if_id_pc_plus1), 32'(m_pc1));
      check("rand_if_id_instr", if_id_instr, m_instr);
      pc_reg = e_next;
      @(negedge clock);
    end
`ifdef FETCH_PERF_EN
    check("rand_perf_fetched", 32'(perf_fetched), 32'(m_fetched));
    check("rand_perf_bubbles", 32'(perf_bubbles), 32'(m_bubbles));
`endif

    // Asynchronous reset asserted mid-WAIT.
    do_reset();
    pc_in = 7'h03; stall = 1'b0; flush = 1'b0; imem_valid = 1'b0;
    @(negedge clock);
    imem_valid = 1'b1; imem_instr = 32'hABCD1234;
    @(posedge clock); #1;
    check("pre_areset_if_id_valid", 32'(if_id_valid), 32'h1);
    check("pre_areset_if_id_instr", if_id_instr, 32'hABCD1234);
    @(negedge clock);
    pc_in = 7'h04; imem_valid = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset_if_id_instr", if_id_instr, 32'h0);
    check("areset_if_id_pc", 32'(if_id_pc), 32'h0);
    check("areset_if_id_pc_plus1", 32'(if_id_pc_plus1), 32'h0);
    check("areset_if_id_valid", 32'(if_id_valid), 32'h0);
    check("areset_imem_req", 32'(imem_req), 32'h1);
`ifdef FETCH_PERF_EN
    check("areset_perf_fetched", 32'(perf_fetched), 32'h0);
    check("areset_perf_bubbles", 32'(perf_bubbles), 32'h0);
`endif
    @(negedge clock);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
